// File: rtl/full_subtractor_pipe.sv
// full_subtractor_pipe: registered ripple-borrow subtract-with-borrow stage with borrow-out and signed overflow
module full_subtractor_pipe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov
);
    logic [WIDTH-1:0] d_next;
    logic             bo_next;
    logic             ov_next;
    logic             br;
    // ripple the borrow through one full-subtractor cell per bit
    always_comb begin
        br     = c;
        d_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            d_next[i] = a[i] ^ b[i] ^ br;
            br        = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bo_next = br;
        ov_next = (a[WIDTH-1] ^ b[WIDTH-1]) & (d_next[WIDTH-1] ^ a[WIDTH-1]);
    end
    // result register loads only on valid input; out_valid tracks in_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            bo        <= 1'b0;
            ov        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d  <= d_next;
                bo <= bo_next;
                ov <= ov_next;
            end
        end
    end
endmodule

// File: tb/tb_full_subtractor_pipe.sv
// tb_full_subtractor_pipe: random and directed checks of WIDTH 1, 8 and 33 against an arithmetic reference
module tb_full_subtractor_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [32:0] a33 = '0, b33 = '0;
    logic c1 = 1'b0, c8 = 1'b0, c33 = 1'b0;
    logic v1, v8, v33, bo1, bo8, bo33, ov1, ov8, ov33;
    logic [0:0]  d1;
    logic [7:0]  d8;
    logic [32:0] d33;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_subtractor_pipe #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .c(c1),
        .out_valid(v1), .d(d1), .bo(bo1), .ov(ov1));
    full_subtractor_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .c(c8),
        .out_valid(v8), .d(d8), .bo(bo8), .ov(ov8));
    full_subtractor_pipe #(.WIDTH(33)) u33 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a33), .b(b33), .c(c33),
        .out_valid(v33), .d(d33), .bo(bo33), .ov(ov33));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // returns {ov, bo, d} from plain integer arithmetic on w-bit operands
    function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b, logic c);
        logic [63:0] m;
        logic [64:0] full;
        longint sa, sb, sd, lim;
        m    = (64'd1 << w) - 64'd1;
        full = {1'b0, a & m} - {1'b0, b & m} - 65'(c);
        lim  = longint'(1) << (w - 1);
        sa   = a[w-1] ? longint'(a & m) - (longint'(1) << w) : longint'(a & m);
        sb   = b[w-1] ? longint'(b & m) - (longint'(1) << w) : longint'(b & m);
        sd   = sa - sb - longint'(c);
        return {(sd > lim - 1) || (sd < -lim), full[w], full[63:0] & m};
    endfunction

    task automatic rand_ops();
        logic [63:0] t;
        a1 = 1'($urandom);
        b1 = 1'($urandom);
        c1 = 1'($urandom);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        c8 = 1'($urandom);
        t = {$urandom, $urandom};
        a33 = t[32:0];
        t = {$urandom, $urandom};
        b33 = t[32:0];
        c33 = 1'($urandom);
    endtask

    // clock one valid vector through every instance and compare with the model
    task automatic tick_check(string tag);
        logic [65:0] e1, e8, e33;
        e1  = model(1, 64'(a1), 64'(b1), c1);
        e8  = model(8, 64'(a8), 64'(b8), c8);
        e33 = model(33, 64'(a33), 64'(b33), c33);
        @(posedge clk);
        #1;
        check({tag, "_v1"}, 64'(v1), 64'd1);
        check({tag, "_d1"}, 64'(d1), e1[63:0]);
        check({tag, "_bo1"}, 64'(bo1), 64'(e1[64]));
        check({tag, "_ov1"}, 64'(ov1), 64'(e1[65]));
        check({tag, "_v8"}, 64'(v8), 64'd1);
        check({tag, "_d8"}, 64'(d8), e8[63:0]);
        check({tag, "_bo8"}, 64'(bo8), 64'(e8[64]));
        check({tag, "_ov8"}, 64'(ov8), 64'(e8[65]));
        check({tag, "_v33"}, 64'(v33), 64'd1);
        check({tag, "_d33"}, 64'(d33), e33[63:0]);
        check({tag, "_bo33"}, 64'(bo33), 64'(e33[64]));
        check({tag, "_ov33"}, 64'(ov33), 64'(e33[65]));
    endtask

    task automatic check_zero(string tag);
        check({tag, "_1"}, {61'd0, v1, d1, bo1, ov1}, 64'd0);
        check({tag, "_8"}, {53'd0, v8, d8, bo8, ov8}, 64'd0);
        check({tag, "_33"}, {28'd0, v33, d33, bo33, ov33}, 64'd0);
    endtask

    task automatic set8(logic [7:0] a, logic [7:0] b, logic c);
        a8 = a;
        b8 = b;
        c8 = c;
    endtask

    initial begin
        logic [1:0] tt [8];
        logic [32:0] hold33;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        #1 rst = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            {a1, b1, c1} = 3'(i);
            tick_check("w1_sweep");
            check("w1_tt", 64'({d1, bo1}), 64'(tt[i]));
        end
        set8(8'h00, 8'h01, 1'b0);
        tick_check("wrap1");
        check("wrap1_fix", {61'd0, d8, bo8, ov8}, {61'd0, 8'hFF, 1'b1, 1'b0});
        set8(8'h00, 8'hFF, 1'b1);
        a33 = '0;
        b33 = '1;
        c33 = 1'b1;
        tick_check("wrap2");
        check("wrap2_fix", {62'd0, d8, bo8}, {62'd0, 8'h00, 1'b1});
        check("wrap2_33", {30'd0, d33, bo33}, {30'd0, 33'd0, 1'b1});
        set8(8'h80, 8'h01, 1'b0);
        tick_check("ovf1");
        check("ovf1_fix", {61'd0, d8, bo8, ov8}, {61'd0, 8'h7F, 1'b0, 1'b1});
        set8(8'h7F, 8'hFF, 1'b0);
        tick_check("ovf2");
        check("ovf2_fix", {61'd0, d8, bo8, ov8}, {61'd0, 8'h80, 1'b1, 1'b1});
        set8(8'h5A, 8'h5A, 1'b0);
        a33 = 33'h1_2345_6789;
        b33 = a33;
        c33 = 1'b1;
        tick_check("eq");
        check("eq_c0", {62'd0, d8, bo8}, 64'd0);
        check("eq_c1", {30'd0, d33, bo33}, {30'd0, {33{1'b1}}, 1'b1});
        set8(8'h10, 8'h03, 1'b0);
        tick_check("gate");
        check("gate_d", 64'(d8), 64'h0D);
        hold33 = d33;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            @(posedge clk);
            #1;
            check("gate_hold8", 64'(d8), 64'h0D);
            check("gate_hold33", 64'(d33), 64'(hold33));
            check("gate_v", {61'd0, v1, v8, v33}, 64'd0);
        end
        in_valid = 1'b1;
        set8(8'h33, 8'h11, 1'b0);
        @(posedge clk);
        set8(8'h44, 8'h01, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1 check_zero("arst");
        @(posedge clk);
        #1 check_zero("arst_ovr");
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("arst_rel");
        set8(8'h20, 8'h05, 1'b1);
        tick_check("post_rst");
        check("post_rst_d", 64'(d8), 64'h1A);
        for (int n = 0; n < 10000; n++) begin
            rand_ops();
            tick_check("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
